// File: rtl/toothless_pkg.sv
// Shared types and constants for the toothless core front end.
// Holds the fetch-unit FSM encoding and the default boot vector.
package toothless_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_e;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instr, pc} entries between memory and decode.
// A flush empties the FIFO and takes priority over a push in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: req/gnt/rvalid memory master feeding
// decode through a small FIFO, with redirect flush and stale-response discard.
module instr_fetch_unit
  import toothless_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FIFO_DEPTH  = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = BOOT_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i,
  output logic                   busy_o
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W   = CNT_W + 2;
  localparam int ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH-1:0] redir_addr_q, redir_addr_d;
  logic                  redir_held_q, redir_held_d;
  logic                  pending_q, pending_d;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  credit_ok;
  logic                  gnt_fire;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_word;

  assign redirect_word = redirect_addr_i & ~ADDR_WIDTH'(3);
  assign credit_ok     = !fifo_full &&
                         ((SUM_W'(outstanding_q) + SUM_W'(fifo_count) + SUM_W'(discard_q))
                          < SUM_W'(FIFO_DEPTH));
  assign pop           = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      outstanding_q <= '0;
      discard_q     <= '0;
      addr_q        <= BOOT_ADDR;
      resp_pc_q     <= BOOT_ADDR;
      redir_addr_q  <= BOOT_ADDR;
      redir_held_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      addr_q        <= addr_d;
      resp_pc_q     <= resp_pc_d;
      redir_addr_q  <= redir_addr_d;
      redir_held_q  <= redir_held_d;
      pending_q     <= pending_d;
    end
  end

  // A redirect that lands while a request is still ungranted is parked in
  // redir_addr_q so the old request stays stable until its grant.
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    addr_d       = addr_q;
    resp_pc_d    = resp_pc_q;
    redir_addr_d = redir_addr_q;
    redir_held_d = redir_held_q;
    instr_req_o  = 1'b0;

    case (state_q)
      FETCH_IDLE: state_d     = FETCH_RUN;
      default:    instr_req_o = pending_q || credit_ok;
    endcase

    gnt_fire      = instr_req_o && instr_gnt_i;
    push          = instr_rvalid_i && !redirect_i && (discard_q == '0);
    drop          = instr_rvalid_i && !push;
    pending_d     = instr_req_o && !instr_gnt_i;
    outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(instr_rvalid_i);

    if (drop && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
    end
    if (gnt_fire) begin
      addr_d       = redir_held_q ? redir_addr_q : addr_q + ADDR_WIDTH'(4);
      redir_held_d = 1'b0;
    end
    if ((state_q == FETCH_FLUSH) && (discard_d == '0)) begin
      state_d = FETCH_RUN;
    end

    if (redirect_i) begin
      discard_d = outstanding_d + CNT_W'(pending_d);
      resp_pc_d = redirect_word;
      if (pending_d) begin
        redir_held_d = 1'b1;
        redir_addr_d = redirect_word;
      end else begin
        addr_d = redirect_word;
      end
      state_d = (discard_d != '0) ? FETCH_FLUSH : FETCH_RUN;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({instr_rdata_i, resp_pc_q}),
    .pop   (pop),
    .flush (redirect_i),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_addr_o  = addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: INSTR_WIDTH];
  assign instr_pc_o    = fifo_empty ? resp_pc_q : fifo_rdata[ADDR_WIDTH-1:0];
  assign busy_o        = (outstanding_q != '0) || (discard_q != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed phases drive a simple
// in-order memory model while a program-order model checks every cycle.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i     = 1'b0;
  logic        instr_rvalid_i  = 1'b0;
  logic [31:0] instr_rdata_i   = '0;
  logic        redirect_i      = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i   = 1'b0;
  logic        busy_o;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  int          grant_cnt = 0;
  int          cyc = 0;
  logic [31:0] seen[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  instr_fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .FIFO_DEPTH  (DEPTH),
    .BOOT_ADDR   (BOOT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_seen(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (idx < seen.size()) ? seen[idx] : 32'hFFFF_FFFF;
    check_output(name, {32'h0, got}, {32'h0, exp});
  endtask

  // In-order memory: a grant sampled in cycle c returns data in cycle c+mem_lat.
  always begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    #4;
    if (!rst && instr_req_o && instr_gnt_i) begin
      mq.push_back('{instr_addr_o, cyc + mem_lat});
    end
  end

  // Program-order model: credits, discards and the next PC decode must see.
  int          m_out, m_disc, m_fifo, new_out;
  logic        m_pending, m_running, m_held;
  logic [31:0] m_next_fetch, m_held_addr, m_exp_pc, ra;
  logic        exp_req, g, rv, pushm, popm;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_redirect = 1'b0, p_rst = 1'b1;
  logic [31:0] p_instr = '0, p_pc = '0;

  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      check_output("rst_req", instr_req_o, 0);
      check_output("rst_addr", instr_addr_o, BOOT);
      check_output("rst_valid", instr_valid_o, 0);
      check_output("rst_instr", instr_o, 0);
      check_output("rst_pc", instr_pc_o, BOOT);
      check_output("rst_busy", busy_o, 0);
      m_out = 0; m_disc = 0; m_fifo = 0;
      m_pending = 0; m_running = 0; m_held = 0;
      m_next_fetch = BOOT; m_held_addr = BOOT; m_exp_pc = BOOT;
    end else begin
      exp_req = m_running && (m_pending || (m_out + m_fifo + m_disc < DEPTH));
      check_output("req", instr_req_o, exp_req);
      if (instr_req_o) check_output("fetch_addr", instr_addr_o, m_next_fetch);
      check_output("valid", instr_valid_o, m_fifo != 0);
      check_output("busy", busy_o, (m_out != 0) || (m_disc != 0));
      if (instr_valid_o) begin
        check_output("head_pc", instr_pc_o, m_exp_pc);
        check_output("head_instr", instr_o, mem_word(m_exp_pc));
      end
      if (p_valid && !p_ready && !p_redirect && !p_rst && instr_valid_o) begin
        check_output("stable_pc", instr_pc_o, p_pc);
        check_output("stable_instr", instr_o, p_instr);
      end
      if (instr_rvalid_i && !redirect_i && m_disc == 0) begin
        check_output("room_on_rvalid", m_fifo < DEPTH, 1);
      end

      g       = instr_req_o && instr_gnt_i;
      rv      = instr_rvalid_i;
      pushm   = rv && !redirect_i && (m_disc == 0);
      popm    = (m_fifo != 0) && instr_ready_i;
      new_out = m_out + int'(g) - int'(rv);
      if (popm) m_exp_pc = m_exp_pc + 32'd4;
      if (redirect_i) m_fifo = 0;
      else            m_fifo = m_fifo + int'(pushm) - int'(popm);
      if (redirect_i)                      m_disc = new_out + int'(instr_req_o && !instr_gnt_i);
      else if (rv && !pushm && m_disc > 0) m_disc = m_disc - 1;
      m_out = new_out;
      if (g) begin
        m_next_fetch = m_held ? m_held_addr : m_next_fetch + 32'd4;
        m_held = 0;
      end
      if (redirect_i) begin
        ra       = redirect_addr_i & ~32'h3;
        m_exp_pc = ra;
        if (instr_req_o && !instr_gnt_i) begin
          m_held      = 1;
          m_held_addr = ra;
        end else begin
          m_next_fetch = ra;
        end
      end
      m_pending = instr_req_o && !instr_gnt_i;
      m_running = 1;
    end
    p_valid    = instr_valid_o;
    p_ready    = instr_ready_i;
    p_redirect = redirect_i;
    p_rst      = rst;
    p_instr    = instr_o;
    p_pc       = instr_pc_o;
  end

  task automatic apply_stimulus(input logic gnt, input logic rdy, input logic redir, input logic [31:0] raddr);
    @(negedge clk);
    instr_gnt_i     = gnt;
    instr_ready_i   = rdy;
    redirect_i      = redir;
    redirect_addr_i = raddr;
    #4;
    if (!rst && instr_valid_o && instr_ready_i) seen.push_back(instr_pc_o);
    if (!rst && instr_req_o && instr_gnt_i) grant_cnt++;
  endtask

  task automatic do_reset(input logic gnt, input logic rdy);
    rst = 1'b1;
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst             = 1'b0;
    instr_gnt_i     = gnt;
    instr_ready_i   = rdy;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    #4;
    seen.delete();
    grant_cnt = 0;
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;

    // Streaming with single-cycle memory: first valid three cycles after release.
    mem_lat = 1;
    do_reset(1'b1, 1'b1);
    check_output("t1_idle_req", instr_req_o, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t1_first_addr", instr_addr_o, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t1_valid_s2", instr_valid_o, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t1_valid_s3", instr_valid_o, 1);
    check_output("t1_pc_s3", instr_pc_o, 32'h0);
    check_output("t1_instr_s3", instr_o, 32'hFFFF_FFFF);
    repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_seen("t1_seq0", 0, 32'h0);
    check_seen("t1_seq1", 1, 32'h4);
    check_seen("t1_seq2", 2, 32'h8);

    // Decode stalled: only DEPTH fetches go out, head held, nothing lost.
    do_reset(1'b1, 1'b0);
    repeat (10) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("t2_grants", grant_cnt, 2);
    check_output("t2_req_off", instr_req_o, 0);
    check_output("t2_head_pc", instr_pc_o, 32'h0);
    seen.delete();
    repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_seen("t2_seq0", 0, 32'h0);
    check_seen("t2_seq1", 1, 32'h4);

    // Grant withheld: request to 0x8 held stable, then advances to 0xC.
    do_reset(1'b1, 1'b1);
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("t3_hold_req", instr_req_o, 1);
      check_output("t3_hold_addr", instr_addr_o, 32'h8);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t3_gnt_addr", instr_addr_o, 32'h8);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t3_next_addr", instr_addr_o, 32'hC);

    // Redirect with two fetches in flight: both responses dropped.
    mem_lat = 3;
    do_reset(1'b1, 1'b1);
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h100);
    seen.delete();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t4_busy", busy_o, 1);
    check_output("t4_valid_off", instr_valid_o, 0);
    repeat (12) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_seen("t4_seq0", 0, 32'h100);
    check_seen("t4_seq1", 1, 32'h104);

    // Redirect (unaligned target) while the request to 0x10 is ungranted.
    mem_lat = 1;
    do_reset(1'b1, 1'b1);
    repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("t5_pend_addr", instr_addr_o, 32'h10);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h203);
    check_output("t5_redir_req", instr_req_o, 1);
    check_output("t5_redir_addr", instr_addr_o, 32'h10);
    seen.delete();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t5_old_addr", instr_addr_o, 32'h10);
    repeat (10) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_seen("t5_seq0", 0, 32'h200);
    check_seen("t5_seq1", 1, 32'h204);

    // Asynchronous reset mid-fetch, then a clean restart from the boot vector.
    mem_lat = 2;
    do_reset(1'b1, 1'b1);
    repeat (5) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("t6_req", instr_req_o, 0);
    check_output("t6_addr", instr_addr_o, BOOT);
    check_output("t6_valid", instr_valid_o, 0);
    check_output("t6_instr", instr_o, 0);
    check_output("t6_pc", instr_pc_o, BOOT);
    check_output("t6_busy", busy_o, 0);
    do_reset(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("t6_restart_req", instr_req_o, 1);
    check_output("t6_restart_addr", instr_addr_o, BOOT);
    repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_seen("t6_seq0", 0, BOOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
